// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer/deserializer state codes and default baud timing.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    STOP    = 3'd5,
    CLEANUP = 3'd6
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty; read data is valid the cycle after the read strobe.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Wr_En,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push;
  logic             pop;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push = i_Wr_En && !o_Full;
  assign pop  = i_Rd_En && !o_Empty;

  // NOTE: count_next is assigned a default before the case so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_Full    <= 1'b0;
      o_Empty   <= 1'b1;
      o_Rd_Data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        o_Rd_Data <= mem[rd_ptr];
      end
      count   <= count_next;
      o_Full  <= (count_next == DEPTH_C);
      o_Empty <= (count_next == '0);
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Wr_Data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start, 8 data bits LSB-first, optional even parity, stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  output logic [2:0] o_SM_State
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  uart_state_t state;
  logic [7:0]  clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_data;
  logic        parity_bit;
  logic        fifo_rd;
  logic [7:0]  fifo_data;
  logic        bit_done;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Wr_En   (i_Tx_DV),
    .i_Wr_Data (i_Tx_Byte),
    .i_Rd_En   (fifo_rd),
    .o_Rd_Data (fifo_data),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty)
  );

  // The head is read while IDLE so it is available in LOAD.
  assign fifo_rd    = (state == IDLE) && !o_Empty;
  assign bit_done   = (clk_cnt == LAST_CNT);
  assign o_SM_State = state;

  // Line, active and done are registered and set on the edge that enters each state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_data  <= '0;
      parity_bit  <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          if (!o_Empty) begin
            state       <= LOAD;
            o_Tx_Active <= 1'b1;
          end
        end
        LOAD: begin
          shift_data  <= fifo_data;
          parity_bit  <= ^fifo_data;
          o_Tx_Serial <= 1'b0;
          state       <= START;
        end
        START: begin
          if (bit_done) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= shift_data[0];
            state       <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                o_Tx_Serial <= parity_bit;
                state       <= PARITY;
              end else begin
                o_Tx_Serial <= 1'b1;
                state       <= STOP;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              shift_data  <= {1'b0, shift_data[7:1]};
              o_Tx_Serial <= shift_data[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= 1'b1;
            state       <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_cnt     <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            state       <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (parity on/off) checked every cycle against a frame-level model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic       serial;
    logic       active;
    logic       done;
    logic [2:0] st;
  } wave_t;

  logic       i_Clock   = 1'b0;
  logic       i_Reset   = 1'b1;
  logic       i_Tx_DV   = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;

  logic [1:0]      full, empty, active, serial, done;
  logic [1:0][2:0] st;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wave_t mk(input logic s, input logic a, input logic d, input logic [2:0] q);
    mk = '{serial: s, active: a, done: d, st: q};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int PE = (g == 0) ? 1 : 0;

    uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY_EN    (PE)
    ) dut (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Tx_DV     (i_Tx_DV),
      .i_Tx_Byte   (i_Tx_Byte),
      .o_Full      (full[g]),
      .o_Empty     (empty[g]),
      .o_Tx_Active (active[g]),
      .o_Tx_Serial (serial[g]),
      .o_Tx_Done   (done[g]),
      .o_SM_State  (st[g])
    );

    logic [7:0] fq[$];
    wave_t      wq[$];
    bit         valid = 1'b0;

    // Model: the byte queue is the FIFO; wq holds the expected outputs of each upcoming cycle.
    always @(posedge i_Clock) begin : step
      logic [7:0] b;
      int         sz;
      bit         was_idle;
      if (i_Reset) begin
        fq.delete();
        wq.delete();
        valid = 1'b1;
      end else begin
        sz       = fq.size();
        was_idle = (wq.size() == 0);
        if (!was_idle) wq.delete(0);
        if (was_idle && sz != 0) begin
          b = fq.pop_front();
          wq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd1));
          for (int c = 0; c < CPB; c++) wq.push_back(mk(1'b0, 1'b1, 1'b0, 3'd2));
          for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) wq.push_back(mk(b[i], 1'b1, 1'b0, 3'd3));
          if (PE != 0)
            for (int c = 0; c < CPB; c++) wq.push_back(mk(^b, 1'b1, 1'b0, 3'd4));
          for (int c = 0; c < CPB; c++) wq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd5));
          wq.push_back(mk(1'b1, 1'b0, 1'b1, 3'd6));
        end
        if (i_Tx_DV && sz != DEPTH) fq.push_back(i_Tx_Byte);
      end
    end

    always @(negedge i_Clock) begin : cmp
      wave_t e;
      if (valid) begin
        e = (wq.size() == 0) ? mk(1'b1, 1'b0, 1'b0, 3'd0) : wq[0];
        check($sformatf("lane%0d serial", g), 32'(serial[g]), 32'(e.serial));
        check($sformatf("lane%0d active", g), 32'(active[g]), 32'(e.active));
        check($sformatf("lane%0d done", g),   32'(done[g]),   32'(e.done));
        check($sformatf("lane%0d state", g),  32'(st[g]),     32'(e.st));
        check($sformatf("lane%0d empty", g),  32'(empty[g]),  32'(fq.size() == 0));
        check($sformatf("lane%0d full", g),   32'(full[g]),   32'(fq.size() == DEPTH));
      end
    end
  end

  // Single write from idle; literal timing of a 44-cycle (parity) and 40-cycle (no parity) frame.
  task automatic send_one(input logic [7:0] b, input logic par);
    for (int n = 0; n <= 60; n++) begin
      case (n)
        0: check("idle empty", 32'(empty[0]), 32'd1);
        1: check("empty after write", 32'(empty[0]), 32'd0);
        2: begin
          check("load state", 32'(st[0]), 32'd1);
          check("load active", 32'(active[0]), 32'd1);
          check("load line", 32'(serial[0]), 32'd1);
        end
        3: begin
          check("start line p", 32'(serial[0]), 32'd0);
          check("start line np", 32'(serial[1]), 32'd0);
        end
        6: check("start end line", 32'(serial[0]), 32'd0);
        7: check("bit0", 32'(serial[0]), 32'(b[0]));
        11: check("bit1", 32'(serial[0]), 32'(b[1]));
        39: begin
          check("parity slot", 32'(serial[0]), 32'(par));
          check("np stop line", 32'(serial[1]), 32'd1);
          check("np stop state", 32'(st[1]), 32'd5);
        end
        43: begin
          check("np done", 32'(done[1]), 32'd1);
          check("p no early done", 32'(done[0]), 32'd0);
        end
        46: check("p stop line", 32'(serial[0]), 32'd1);
        47: check("p done", 32'(done[0]), 32'd1);
        default: ;
      endcase
      i_Tx_DV   = (n == 0);
      i_Tx_Byte = (n == 0) ? b : ~b;
      @(negedge i_Clock);
    end
  endtask

  initial begin : stim
    bit burst;
    burst = 1'b0;
    repeat (3) @(negedge i_Clock);
    check("rst serial", 32'(serial[0]), 32'd1);
    check("rst active", 32'(active[0]), 32'd0);
    check("rst done", 32'(done[0]), 32'd0);
    check("rst full", 32'(full[0]), 32'd0);
    check("rst empty", 32'(empty[0]), 32'd1);
    check("rst state", 32'(st[0]), 32'd0);
    i_Reset = 1'b0;
    @(negedge i_Clock);

    send_one(8'hA5, 1'b0);
    send_one(8'h07, 1'b1);

    // Burst of ten writes, then one write exactly on the IDLE pop while full.
    for (int n = 0; n < 520; n++) begin
      if (n == 8)  check("burst not yet full", 32'(full[0]), 32'd0);
      if (n == 9)  check("burst full", 32'(full[0]), 32'd1);
      if (n == 48) begin
        check("pop cycle full", 32'(full[0]), 32'd1);
        check("pop cycle idle", 32'(st[0]), 32'd0);
      end
      if (n == 49) check("full clears after pop", 32'(full[0]), 32'd0);
      i_Tx_DV   = (n < 10) || (n == 48);
      i_Tx_Byte = (n < 10) ? 8'(n) : 8'hEE;
      @(negedge i_Clock);
    end

    // Reset during data bit 3 with a second byte still queued.
    for (int n = 0; n <= 40; n++) begin
      if (n == 20) check("in data", 32'(st[0]), 32'd3);
      if (n == 21) begin
        check("abort line", 32'(serial[0]), 32'd1);
        check("abort active", 32'(active[0]), 32'd0);
        check("abort empty", 32'(empty[0]), 32'd1);
        check("abort np line", 32'(serial[1]), 32'd1);
      end
      i_Tx_DV   = (n < 2);
      i_Tx_Byte = (n == 0) ? 8'h3C : 8'h99;
      i_Reset   = (n == 20);
      @(negedge i_Clock);
    end
    send_one(8'h3C, 1'b0);

    send_one(8'h55, 1'b0);
    send_one(8'hFF, 1'b0);
    send_one(8'h00, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) burst = !burst;
      i_Tx_DV   = burst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      i_Tx_Byte = 8'($urandom);
      i_Reset   = ($urandom_range(0, 1999) == 0);
      @(negedge i_Clock);
    end

    i_Reset = 1'b0;
    i_Tx_DV = 1'b0;
    repeat (600) @(negedge i_Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
